// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: shared widths, ALUOp encodings and register-zero index for the ID/EX operand stage.
package alu_operand_stage_pkg;
  localparam int W = 32;
  localparam int RW = 5;
  localparam int OPW = 3;
  localparam logic [RW-1:0] REG_ZERO = '0;
  typedef enum logic [OPW-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_e;
  typedef struct packed {
    logic           valid;
    logic [OPW-1:0] aluop;
    logic [RW-1:0]  rd;
    logic [RW-1:0]  rs;
    logic [RW-1:0]  rt;
    logic [W-1:0]   rs_data;
    logic [W-1:0]   rt_data;
    logic [W-1:0]   imm;
    logic           use_imm;
  } stage_t;
endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// alu_operand_stage_fwd_mux: picks EX/MEM, then MEM/WB, then stored data for one source operand.
// Forwarding exists only when ALU_FWD_EN is defined; otherwise the stored value passes straight through.
module alu_operand_stage_fwd_mux
  import alu_operand_stage_pkg::*;
(
  input  logic [RW-1:0] idx,
  input  logic [W-1:0]  stored,
  input  logic          exm_we,
  input  logic [RW-1:0] exm_rd,
  input  logic [W-1:0]  exm_data,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_rd,
  input  logic [W-1:0]  wb_data,
  output logic [W-1:0]  operand
);
`ifdef ALU_FWD_EN
  logic live;
  always_comb begin
    live = idx != REG_ZERO;
    operand = (live && exm_we && exm_rd == idx) ? exm_data :
              (live && wb_we && wb_rd == idx) ? wb_data : stored;
  end
`else
  logic unused_fwd;
  always_comb begin
    unused_fwd = ^{idx, exm_we, exm_rd, exm_data, wb_we, wb_rd, wb_data};
    operand = stored;
  end
`endif
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register with stall/flush and operand forwarding into the EX-stage alu.
// Build with ALU_FWD_EN defined to forward from EX/MEM and MEM/WB; without it operands come from the register file only.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [RW-1:0]  in_rs,
  input  logic [RW-1:0]  in_rt,
  input  logic [W-1:0]   in_rs_data,
  input  logic [W-1:0]   in_rt_data,
  input  logic [W-1:0]   in_imm,
  input  logic           in_use_imm,
  input  logic [OPW-1:0] in_aluop,
  input  logic [RW-1:0]  in_rd,
  input  logic           stall,
  input  logic           flush,
  input  logic           exm_we,
  input  logic [RW-1:0]  exm_rd,
  input  logic [W-1:0]   exm_data,
  input  logic           wb_we,
  input  logic [RW-1:0]  wb_rd,
  input  logic [W-1:0]   wb_data,
  output logic [W-1:0]   A,
  output logic [W-1:0]   B,
  output logic [OPW-1:0] ALUOp,
  output logic [RW-1:0]  ex_rd,
  output logic           ex_valid
);
  stage_t q;
  logic [W-1:0] fwd_a, fwd_b;
  alu_operand_stage_fwd_mux u_fwd_a (
    .idx(q.rs), .stored(q.rs_data),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(fwd_a)
  );
  alu_operand_stage_fwd_mux u_fwd_b (
    .idx(q.rt), .stored(q.rt_data),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(fwd_b)
  );
  // A stall re-captures the forwarded operands so a value retiring from MEM/WB mid-stall survives.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (flush) q <= '0;
    else if (stall) begin
      q.rs_data <= fwd_a;
      q.rt_data <= fwd_b;
    end else q <= '{valid: in_valid, aluop: in_aluop, rd: in_rd, rs: in_rs, rt: in_rt,
                    rs_data: in_rs_data, rt_data: in_rt_data, imm: in_imm, use_imm: in_use_imm};
  always_comb begin
    in_ready = ~stall;
    A = fwd_a;
    B = q.use_imm ? q.imm : fwd_b;
    ALUOp = q.aluop;
    ex_rd = q.rd;
    ex_valid = q.valid;
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vector table, async-reset sequence and randomized run against a stage model.
module tb_alu_operand_stage;
`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [31:0] FA = FWD ? 32'hAAAA : 32'h10;
  localparam logic [31:0] FB = FWD ? 32'h55 : 32'h20;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_use_imm, stall, flush, exm_we, wb_we, ex_valid;
  logic [4:0] in_rs, in_rt, in_rd, exm_rd, wb_rd, ex_rd;
  logic [31:0] in_rs_data, in_rt_data, in_imm, exm_data, wb_data, A, B;
  logic [2:0] in_aluop, ALUOp;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_aluop(in_aluop), .in_rd(in_rd),
    .stall(stall), .flush(flush),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .A(A), .B(B), .ALUOp(ALUOp), .ex_rd(ex_rd), .ex_valid(ex_valid)
  );

  // Model of what the stage holds: the instruction and the operand values it believes in.
  typedef struct packed {
    logic valid;
    logic [2:0] op;
    logic [4:0] rd, rs, rt;
    logic [31:0] rsv, rtv, imm;
    logic use_imm;
  } mst_t;
  mst_t m, nxt;

  typedef struct {
    logic iv; logic [4:0] rs; logic [31:0] rsd; logic [4:0] rt; logic [31:0] rtd;
    logic [31:0] imm; logic ui; logic [2:0] op; logic [4:0] rd;
    logic st, fl, ew; logic [4:0] er; logic [31:0] ed; logic ww; logic [4:0] wr; logic [31:0] wd;
    logic chk, ev; logic [31:0] ea, eb; logic [2:0] eo; logic [4:0] erd;
  } vec_t;
  vec_t vq[$];

  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] held);
    if (FWD && idx != 5'd0 && exm_we && exm_rd == idx) return exm_data;
    if (FWD && idx != 5'd0 && wb_we && wb_rd == idx) return wb_data;
    return held;
  endfunction

  function automatic mst_t model_next();
    mst_t n = m;
    if (flush) n = '0;
    else if (stall) begin
      n.rsv = resolve(m.rs, m.rsv);
      n.rtv = resolve(m.rt, m.rtv);
    end else n = '{valid: in_valid, op: in_aluop, rd: in_rd, rs: in_rs, rt: in_rt,
                   rsv: in_rs_data, rtv: in_rt_data, imm: in_imm, use_imm: in_use_imm};
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [4:0] rs, input logic [31:0] rsd,
                     input logic [4:0] rt, input logic [31:0] rtd, input logic [31:0] imm,
                     input logic ui, input logic [2:0] op, input logic [4:0] rd,
                     input logic st, input logic fl,
                     input logic ew, input logic [4:0] er, input logic [31:0] ed,
                     input logic ww, input logic [4:0] wr, input logic [31:0] wd,
                     input logic c, input logic ev, input logic [31:0] ea, input logic [31:0] eb,
                     input logic [2:0] eo, input logic [4:0] erd);
    vq.push_back('{iv, rs, rsd, rt, rtd, imm, ui, op, rd, st, fl, ew, er, ed, ww, wr, wd,
                   c, ev, ea, eb, eo, erd});
  endtask

  task automatic apply(input vec_t v);
    in_valid = v.iv; in_rs = v.rs; in_rs_data = v.rsd; in_rt = v.rt; in_rt_data = v.rtd;
    in_imm = v.imm; in_use_imm = v.ui; in_aluop = v.op; in_rd = v.rd;
    stall = v.st; flush = v.fl;
    exm_we = v.ew; exm_rd = v.er; exm_data = v.ed;
    wb_we = v.ww; wb_rd = v.wr; wb_data = v.wd;
  endtask

  task automatic advance();
    nxt = model_next();
    @(posedge clk);
    m = nxt;
    @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic all_fields, input logic ev,
                               input logic [31:0] ea, input logic [31:0] eb,
                               input logic [2:0] eo, input logic [4:0] erd);
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, ev});
    if (all_fields || ev) begin
      chk({tag, ".A"}, A, ea);
      chk({tag, ".B"}, B, eb);
      chk({tag, ".ALUOp"}, {29'd0, ALUOp}, {29'd0, eo});
      chk({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, erd});
    end
  endtask

  initial begin
    vec_t z;
    z = '{default: '0};
    apply(z);
    rst_n = 1'b0;
    m = '0;
    repeat (2) @(negedge clk);
    #1 check_outputs("reset", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    add(1, 3, 32'h10, 4, 32'h20, 32'h0, 0, 3'd0, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0,
        1, 0, 32'h0, 32'h0, 3'd0, 5'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 32'hAAAA, 1, 3, 32'hBBBB,
        1, 1, FA, 32'h20, 3'd0, 5'd7);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 32'h55,
        1, 1, FA, FB, 3'd0, 5'd7);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,
        1, 1, FA, FB, 3'd0, 5'd7);
    add(1, 0, 32'h0, 4, 32'h20, 32'h8000_0000, 1, 3'd5, 5'd9, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0,
        1, 1, FA, FB, 3'd0, 5'd7);
    add(1, 1, 32'h1, 1, 32'h1, 0, 0, 3'd1, 5'd1, 1, 1, 1, 0, 32'hFFFF, 1, 0, 32'h1234,
        1, 1, 32'h0, 32'h8000_0000, 3'd5, 5'd9);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        1, 0, 32'h0, 32'h0, 3'd0, 5'd0);
    add(1, 5, 32'h77, 6, 32'h88, 0, 0, 3'd2, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        1, 1, 32'h77, 32'h88, 3'd2, 5'd3);

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i]);
      #1 check_outputs($sformatf("vec%0d", i), vq[i].chk, vq[i].ev, vq[i].ea, vq[i].eb, vq[i].eo, vq[i].erd);
      advance();
    end

    // Asynchronous reset in the middle of a stall drops the held instruction at once.
    apply(z);
    in_valid = 1'b1; in_rs = 5'd2; in_rs_data = 32'h11; in_rt = 5'd3; in_rt_data = 32'h22;
    in_aluop = 3'd4; in_rd = 5'd6;
    advance();
    stall = 1'b1;
    #1 check_outputs("pre_rst", 1'b1, 1'b1, 32'h11, 32'h22, 3'd4, 5'd6);
    #2 rst_n = 1'b0;
    #1 check_outputs("mid_rst", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(z);
    m = '0;

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ea, eb;
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_rs = 5'($urandom_range(0, 7)); in_rt = 5'($urandom_range(0, 7));
      in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom;
      in_use_imm = 1'($urandom_range(0, 1)); in_aluop = 3'($urandom_range(0, 5));
      in_rd = 5'($urandom_range(0, 31));
      stall = 1'($urandom_range(0, 3) == 0); flush = 1'($urandom_range(0, 9) == 0);
      exm_we = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 7)); exm_data = $urandom;
      wb_we = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      #1;
      ea = resolve(m.rs, m.rsv);
      eb = m.use_imm ? m.imm : resolve(m.rt, m.rtv);
      chk("rand.in_ready", {31'd0, in_ready}, {31'd0, ~stall});
      check_outputs($sformatf("rand%0d", i), 1'b0, m.valid, ea, eb, m.op, m.rd);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
